uart_rx_tick_gen: RTL and testbench

Runtime-configurable receive timing generator for the UART RX path. On a start request it produces oversampled sample ticks, a mid-bit strobe, end-of-bit strobes and a running bit index. It ends the frame automatically after a programmed number of bits. It sits between the start-bit edge detector and the RX shift/vote logic. It adds runtime baud selection, configurable oversampling and frame tracking.

---
 rtl/uart_pkg.sv | 63 ++++++
 rtl/uart_baud_div_rom.sv | 26 ++
 rtl/uart_rx_tick_gen.sv | 143 ++++++++++++++
 tb/tb_uart_rx_tick_gen.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud rate table, divisor helpers and RX timing state encoding.
package uart_pkg;

    localparam int unsigned NUM_BAUD = 8;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } rx_state_e;

    function automatic int unsigned baud_rate(input int unsigned code);
        case (code)
            0:       return 9600;
            1:       return 19200;
            2:       return 38400;
            3:       return 57600;
            4:       return 115200;
            5:       return 230400;
            6:       return 460800;
            default: return 921600;
        endcase
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        longint unsigned p;
        int unsigned     r;
        p = 64'd1;
        r = 0;
        while (p < 64'(value)) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Sample period minus one; rates too fast for the clock clamp to a period of one cycle.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned oversample,
                                             input int unsigned code);
        int unsigned q;
        q = clk_freq / (baud_rate(code) * oversample);
        return (q == 0) ? 0 : q - 1;
    endfunction

    function automatic int unsigned max_div(input int unsigned clk_freq,
                                            input int unsigned oversample);
        int unsigned m;
        m = 0;
        for (int unsigned k = 0; k < NUM_BAUD; k++) begin
            if (baud_div(clk_freq, oversample, k) > m) m = baud_div(clk_freq, oversample, k);
        end
        return m;
    endfunction

    // Never narrower than one bit, even when every rate collapses to DIV = 0.
    function automatic int unsigned div_width(input int unsigned clk_freq,
                                              input int unsigned oversample);
        int unsigned w;
        w = clog2(max_div(clk_freq, oversample) + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_baud_div_rom.sv
// Combinational baud code to prescaler divisor lookup, resolved at elaboration.
module uart_baud_div_rom
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 125_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = div_width(CLK_FREQ, OVERSAMPLE)
) (
    input  logic [2:0]       baud_sel,
    output logic [DIV_W-1:0] div
);

    localparam logic [DIV_W-1:0] DIV_TABLE [NUM_BAUD] = '{
        DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, 0)),
        DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, 1)),
        DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, 2)),
        DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, 3)),
        DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, 4)),
        DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, 5)),
        DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, 6)),
        DIV_W'(baud_div(CLK_FREQ, OVERSAMPLE, 7))
    };

    assign div = DIV_TABLE[baud_sel];

endmodule

// File: rtl/uart_rx_tick_gen.sv
// UART RX timing generator: oversampled sample ticks, bit-centre and end-of-bit strobes,
// running bit index and automatic end of frame.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 125_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FRAME_BITS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] baud_sel,
    input  logic       rx_start,
    input  logic       rx_done,
    output logic       busy,
    output logic       sample_tick,
    output logic       mid_tick,
    output logic       bit_tick,
    output logic [3:0] bit_idx,
    output logic       frame_end
);

    localparam int unsigned DIV_W = div_width(CLK_FREQ, OVERSAMPLE);
    localparam int unsigned PH_W  = clog2(OVERSAMPLE);

    localparam logic [PH_W-1:0] PH_MID    = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(OVERSAMPLE - 1);
    localparam logic [3:0]      FRAME_LEN = 4'(FRAME_BITS);

    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             sample_tick_q, sample_tick_d;
    logic             mid_tick_q, mid_tick_d;
    logic             bit_tick_q, bit_tick_d;
    logic             frame_end_q, frame_end_d;
    logic [DIV_W-1:0] rom_div;
    logic             evt;

    uart_baud_div_rom #(
        .CLK_FREQ   (CLK_FREQ),
        .OVERSAMPLE (OVERSAMPLE),
        .DIV_W      (DIV_W)
    ) u_div_rom (
        .baud_sel (baud_sel),
        .div      (rom_div)
    );

    assign evt = (state_q == StRun) && (pre_cnt_q == div_q);

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        pre_cnt_d     = pre_cnt_q;
        phase_d       = phase_q;
        bit_idx_d     = bit_idx_q;
        sample_tick_d = 1'b0;
        mid_tick_d    = 1'b0;
        bit_tick_d    = 1'b0;
        frame_end_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (rx_start) begin
                    state_d   = StRun;
                    div_d     = rom_div;
                    pre_cnt_d = '0;
                    phase_d   = '0;
                    bit_idx_d = '0;
                end
            end

            StRun: begin
                if (evt) begin
                    pre_cnt_d = '0;
                    phase_d   = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                end else begin
                    pre_cnt_d = pre_cnt_q + DIV_W'(1);
                end

                sample_tick_d = evt;
                mid_tick_d    = evt && (phase_q == PH_MID);
                bit_tick_d    = evt && (phase_q == PH_LAST);

                if (bit_tick_d) begin
                    bit_idx_d = (bit_idx_q == 4'hf) ? 4'hf : bit_idx_q + 4'd1;
                    if (bit_idx_d == FRAME_LEN) begin
                        frame_end_d = 1'b1;
                        state_d     = StIdle;
                    end
                end

                // An abort still lets a coinciding tick out, but nothing after it.
                if (rx_done) state_d = StIdle;

                if (state_d == StIdle) begin
                    pre_cnt_d = '0;
                    phase_d   = '0;
                end
            end

            default: begin
                state_d   = StIdle;
                pre_cnt_d = '0;
                phase_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            div_q         <= '0;
            pre_cnt_q     <= '0;
            phase_q       <= '0;
            bit_idx_q     <= '0;
            sample_tick_q <= 1'b0;
            mid_tick_q    <= 1'b0;
            bit_tick_q    <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            pre_cnt_q     <= pre_cnt_d;
            phase_q       <= phase_d;
            bit_idx_q     <= bit_idx_d;
            sample_tick_q <= sample_tick_d;
            mid_tick_q    <= mid_tick_d;
            bit_tick_q    <= bit_tick_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign sample_tick = sample_tick_q;
    assign mid_tick    = mid_tick_q;
    assign bit_tick    = bit_tick_q;
    assign bit_idx     = bit_idx_q;
    assign frame_end   = frame_end_q;

endmodule

// File: tb/tb_uart_rx_tick_gen.sv
// Scoreboard bench for uart_rx_tick_gen: stimulus queues expected ticks, a monitor checks them.
module tb_uart_rx_tick_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] baud_sel = 3'd0;
    logic       rx_start = 1'b0;
    logic       rx_done = 1'b0;
    logic       busy, sample_tick, mid_tick, bit_tick, frame_end;
    logic [3:0] bit_idx;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct packed {
        int        cyc;
        logic [7:0] flags;  // {sample, mid, bit, frame_end, bit_idx[3:0]}
    } exp_t;

    exp_t exp_q[$];

    uart_rx_tick_gen #(
        .CLK_FREQ   (614_400),
        .OVERSAMPLE (16),
        .FRAME_BITS (10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .baud_sel    (baud_sel),
        .rx_start    (rx_start),
        .rx_done     (rx_done),
        .busy        (busy),
        .sample_tick (sample_tick),
        .mid_tick    (mid_tick),
        .bit_tick    (bit_tick),
        .bit_idx     (bit_idx),
        .frame_end   (frame_end)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Expected tick stream for a frame started at t0 with sample period p, cut off after tend.
    task automatic push_frame(input int t0, input int p, input int tend);
        exp_t e;
        for (int n = 1; n <= 160; n++) begin
            if (t0 + n * p > tend) break;
            e.cyc   = t0 + n * p;
            e.flags = {1'b1, (n % 16) == 8, (n % 16) == 0, n == 160, 4'(n / 16)};
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(output int t0);
        t0 = cyc + 1;
        rx_start = 1'b1;
        @(negedge clk);
        rx_start = 1'b0;
    endtask

    // Monitor: every cycle carrying any tick must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sample_tick === 1'b1 || mid_tick === 1'b1 || bit_tick === 1'b1 ||
                frame_end === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tick", {56'd0, sample_tick, mid_tick, bit_tick, frame_end,
                        bit_idx}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tick_cycle", 64'(cyc), 64'(e.cyc));
                    chk("tick_flags", {56'd0, sample_tick, mid_tick, bit_tick, frame_end,
                        bit_idx}, {56'd0, e.flags});
                end
            end
        end
    end

    initial begin
        int t0;
        int t1;
        @(negedge clk);

        // Reset then idle.
        at_cyc(3);
        chk("reset_outputs", {55'd0, busy, sample_tick, mid_tick, bit_tick, frame_end, bit_idx},
            64'd0);
        reset_n = 1'b1;
        at_cyc(103);
        chk("idle_outputs", {55'd0, busy, sample_tick, mid_tick, bit_tick, frame_end, bit_idx},
            64'd0);

        // Full frame at DIV=3.
        baud_sel = 3'd0;
        start_frame(t0);
        chk("full_busy_t0", 64'(busy), 64'd1);
        push_frame(t0, 4, t0 + 100000);
        at_cyc(t0 + 639);
        chk("full_busy_before_end", 64'(busy), 64'd1);
        chk("full_idx_before_end", 64'(bit_idx), 64'd9);
        at_cyc(t0 + 640);
        chk("full_busy_end", 64'(busy), 64'd0);
        chk("full_idx_end", 64'(bit_idx), 64'd10);
        at_cyc(t0 + 680);
        chk("full_leftover", 64'(exp_q.size()), 64'd0);

        // Abort at DIV=1, done coincides with a tick at T0+50.
        baud_sel = 3'd1;
        start_frame(t0);
        push_frame(t0, 2, t0 + 50);
        at_cyc(t0 + 49);
        rx_done = 1'b1;
        at_cyc(t0 + 50);
        rx_done = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        at_cyc(t0 + 80);
        chk("abort_idx_hold", 64'(bit_idx), 64'd1);
        chk("abort_leftover", 64'(exp_q.size()), 64'd0);

        // Baud change mid-frame, then immediate rearm after frame_end.
        baud_sel = 3'd0;
        start_frame(t0);
        push_frame(t0, 4, t0 + 100000);
        at_cyc(t0 + 19);
        baud_sel = 3'd1;
        at_cyc(t0 + 640);
        chk("chg_frame_end", 64'(frame_end), 64'd1);
        start_frame(t1);
        chk("rearm_busy", 64'(busy), 64'd1);
        chk("rearm_idx", 64'(bit_idx), 64'd0);
        push_frame(t1, 2, t1 + 40);
        at_cyc(t1 + 39);
        rx_done = 1'b1;
        at_cyc(t1 + 40);
        rx_done = 1'b0;
        chk("rearm_abort_busy", 64'(busy), 64'd0);
        chk("rearm_abort_idx", 64'(bit_idx), 64'd1);
        at_cyc(t1 + 60);
        chk("chg_leftover", 64'(exp_q.size()), 64'd0);

        // Collision in IDLE: start wins. Collision in RUN: done wins.
        baud_sel = 3'd2;
        rx_done = 1'b1;
        start_frame(t0);
        rx_done = 1'b0;
        chk("coll_idle_busy", 64'(busy), 64'd1);
        push_frame(t0, 1, t0 + 10);
        at_cyc(t0 + 9);
        rx_start = 1'b1;
        rx_done = 1'b1;
        at_cyc(t0 + 10);
        rx_start = 1'b0;
        rx_done = 1'b0;
        chk("coll_run_busy", 64'(busy), 64'd0);
        at_cyc(t0 + 20);
        chk("coll_leftover", 64'(exp_q.size()), 64'd0);

        // Start re-asserted in RUN is ignored: tick schedule stays anchored to T0.
        baud_sel = 3'd0;
        start_frame(t0);
        push_frame(t0, 4, t0 + 100);
        at_cyc(t0 + 9);
        rx_start = 1'b1;
        at_cyc(t0 + 10);
        rx_start = 1'b0;
        at_cyc(t0 + 99);
        rx_done = 1'b1;
        at_cyc(t0 + 100);
        rx_done = 1'b0;
        chk("restart_ign_idx", 64'(bit_idx), 64'd1);
        at_cyc(t0 + 120);
        chk("restart_ign_leftover", 64'(exp_q.size()), 64'd0);

        // Reset mid-frame, then a clean restart.
        start_frame(t0);
        push_frame(t0, 4, t0 + 99);
        at_cyc(t0 + 99);
        reset_n = 1'b0;
        at_cyc(t0 + 100);
        chk("midreset_outputs", {55'd0, busy, sample_tick, mid_tick, bit_tick, frame_end,
            bit_idx}, 64'd0);
        reset_n = 1'b1;
        at_cyc(t0 + 110);
        chk("midreset_idle", 64'(busy), 64'd0);
        baud_sel = 3'd2;
        start_frame(t1);
        chk("midreset_restart_busy", 64'(busy), 64'd1);
        chk("midreset_restart_idx", 64'(bit_idx), 64'd0);
        push_frame(t1, 1, t1 + 5);
        at_cyc(t1 + 4);
        rx_done = 1'b1;
        at_cyc(t1 + 5);
        rx_done = 1'b0;
        at_cyc(t1 + 20);
        chk("midreset_leftover", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
